// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle RV32I integer slice (R-type, I-type ALU, LUI).
// Instructions step through FETCH/DECODE/EXECUTE/WRITEBACK. Illegal encodings
// latch a sticky trap and halt the block until reset.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instrReq,
  output logic [XLEN-1:0] instrMemAddr,
  input  logic            instrValid,
  input  logic [31:0]     instrCode,
  output logic            retire,
  output logic [XLEN-1:0] retirePC,
  output logic            trap,
  input  logic [4:0]      dbgAddr,
  output logic [XLEN-1:0] dbgData
);

  localparam int              SHW     = $clog2(XLEN);
  localparam int              RW      = $clog2(NREGS);
  localparam logic [6:0]      OP_R    = 7'b0110011;
  localparam logic [6:0]      OP_I    = 7'b0010011;
  localparam logic [6:0]      OP_LUI  = 7'b0110111;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_TRAP      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d;
  logic [XLEN-1:0] retire_pc_q, retire_pc_d;
  logic            instr_req_q, instr_req_d, retire_q, retire_d, trap_q, trap_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic [6:0]        opcode_s, funct7_s;
  logic [2:0]        funct3_s;
  logic [4:0]        rd_s, rs1_s, rs2_s;
  logic signed [11:0] imm_i_s;
  logic signed [31:0] imm_u_s;
  logic [XLEN-1:0]   imm_sel_s, op2_s, alu_s;
  logic [SHW-1:0]    shamt_s;
  logic              is_r_s, legal_s, shift_zero_s, shift_alt_s;

  // An architectural register index is only usable below NREGS (RV32E has 16).
  function automatic logic idx_ok(input logic [4:0] idx);
    return (32'(idx) < 32'(NREGS));
  endfunction

  assign opcode_s = ir_q[6:0];
  assign rd_s     = ir_q[11:7];
  assign funct3_s = ir_q[14:12];
  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];
  assign funct7_s = ir_q[31:25];
  assign imm_i_s  = ir_q[31:20];
  assign imm_u_s  = {ir_q[31:12], 12'h000};
  assign is_r_s   = (opcode_s == OP_R);
  assign op2_s    = is_r_s ? b_q : imm_q;
  assign shamt_s  = op2_s[SHW-1:0];

  // Pick the sign-extended immediate: U-type for LUI, I-type otherwise.
  always_comb begin
    imm_sel_s = XLEN'(imm_i_s);
    if (opcode_s == OP_LUI) begin
      imm_sel_s = XLEN'(imm_u_s);
    end else begin
      imm_sel_s = XLEN'(imm_i_s);
    end
  end

  // Shift-immediate upper bits: funct7 on XLEN=32, funct6 on XLEN=64 (bit 25 is shamt[5]).
  always_comb begin
    shift_zero_s = 1'b0;
    shift_alt_s  = 1'b0;
    if (XLEN == 64) begin
      shift_zero_s = (ir_q[31:26] == 6'b000000);
      shift_alt_s  = (ir_q[31:26] == 6'b010000);
    end else begin
      shift_zero_s = (funct7_s == 7'b0000000);
      shift_alt_s  = (funct7_s == 7'b0100000);
    end
  end

  // Legality of the instruction held in IR, including register index range.
  always_comb begin
    legal_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        if (funct7_s == 7'b0000000) begin
          legal_s = 1'b1;
        end else if (funct7_s == 7'b0100000) begin
          legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
        legal_s = legal_s && idx_ok(rs1_s) && idx_ok(rs2_s) && idx_ok(rd_s);
      end
      OP_I: begin
        case (funct3_s)
          3'b001:  legal_s = shift_zero_s;
          3'b101:  legal_s = shift_zero_s || shift_alt_s;
          default: legal_s = 1'b1;
        endcase
        legal_s = legal_s && idx_ok(rs1_s) && idx_ok(rd_s);
      end
      OP_LUI:  legal_s = idx_ok(rd_s);
      default: legal_s = 1'b0;
    endcase
  end

  // ALU: bit 30 selects SUB only for R-type (it is immediate data for ADDI), SRA/SRAI for both.
  always_comb begin
    alu_s = {XLEN{1'b0}};
    if (opcode_s == OP_LUI) begin
      alu_s = imm_q;
    end else begin
      case (funct3_s)
        3'b000: begin
          if (is_r_s && ir_q[30]) alu_s = a_q - op2_s;
          else                    alu_s = a_q + op2_s;
        end
        3'b001: alu_s = a_q << shamt_s;
        3'b010: alu_s = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op2_s))};
        3'b011: alu_s = {{(XLEN-1){1'b0}}, (a_q < op2_s)};
        3'b100: alu_s = a_q ^ op2_s;
        3'b101: begin
          if (ir_q[30]) alu_s = $unsigned($signed(a_q) >>> shamt_s);
          else          alu_s = a_q >> shamt_s;
        end
        3'b110: alu_s = a_q | op2_s;
        3'b111: alu_s = a_q & op2_s;
        default: alu_s = {XLEN{1'b0}};
      endcase
    end
  end

  // Debug read port; x0 and out-of-range indices read as zero.
  always_comb begin
    dbgData = {XLEN{1'b0}};
    if ((dbgAddr != 5'd0) && idx_ok(dbgAddr)) begin
      dbgData = regs_q[dbgAddr[RW-1:0]];
    end else begin
      dbgData = {XLEN{1'b0}};
    end
  end

  // Next-state and datapath updates for the instruction sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    retire_d    = 1'b0;
    retire_pc_d = retire_pc_q;
    trap_d      = trap_q;
    regs_d      = regs_q;
    case (state_q)
      S_FETCH: begin
        if (instr_req_q && instrValid) begin
          ir_d    = instrCode;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs1_s[RW-1:0]];
        b_d   = regs_q[rs2_s[RW-1:0]];
        imm_d = imm_sel_s;
        if (legal_s) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_d       = alu_s;
        retire_d    = 1'b1;
        retire_pc_d = pc_q;
        state_d     = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (rd_s != 5'd0) begin
          regs_d[rd_s[RW-1:0]] = alu_q;
        end else begin
          regs_d = regs_q;
        end
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
    endcase
    instr_req_d = (state_d == S_FETCH);
  end

  // State registers; reset discards any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0000_0000;
      a_q         <= {XLEN{1'b0}};
      b_q         <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      alu_q       <= {XLEN{1'b0}};
      retire_pc_q <= {XLEN{1'b0}};
      instr_req_q <= 1'b0;
      retire_q    <= 1'b0;
      trap_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      retire_pc_q <= retire_pc_d;
      instr_req_q <= instr_req_d;
      retire_q    <= retire_d;
      trap_q      <= trap_d;
      regs_q      <= regs_d;
    end
  end

  assign instrReq     = instr_req_q;
  assign instrMemAddr = pc_q;
  assign retire       = retire_q;
  assign retirePC     = retire_pc_q;
  assign trap         = trap_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed bench for multicycle_datapath. Two instances
// (NREGS=32 and NREGS=16) share the instruction stream; retirements are matched
// against a scoreboard of expected {pc, rd, value}.
`timescale 1ns/1ps
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [31:0] instrCode;
  logic [4:0]  dbgAddr;

  logic        req_a, ret_a, trap_a;
  logic [31:0] addr_a, rpc_a, dbg_a;
  logic        req_b, ret_b, trap_b;
  logic [31:0] addr_b, rpc_b, dbg_b;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pc_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .instrReq(req_a), .instrMemAddr(addr_a),
    .instrValid(instrValid), .instrCode(instrCode), .retire(ret_a),
    .retirePC(rpc_a), .trap(trap_a), .dbgAddr(dbgAddr), .dbgData(dbg_a)
  );

  multicycle_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0000_0000)) dut_b (
    .clk(clk), .reset(reset), .instrReq(req_b), .instrMemAddr(addr_b),
    .instrValid(instrValid), .instrCode(instrCode), .retire(ret_b),
    .retirePC(rpc_b), .trap(trap_b), .dbgAddr(dbgAddr), .dbgData(dbg_b)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges for a fetch request, then check its address.
  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!req_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("fetch_req", req_a, 1'b1);
    chk32("fetch_addr", addr_a, pc_m);
  endtask

  // Present one instruction after 'waits' stall cycles; returns just after the accepting edge.
  task automatic fetch(input logic [31:0] code, input int waits);
    wait_req();
    for (int i = 0; i < waits; i++) begin
      instrValid = 1'b0;
      instrCode  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("stall_req", req_a, 1'b1);
      chk32("stall_addr", addr_a, pc_m);
    end
    instrValid = 1'b1;
    instrCode  = code;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    instrCode  = 32'h0000_0000;
  endtask

  // Issue a legal instruction and check retirement timing, PC and the written register.
  task automatic run(input logic [31:0] code, input int waits, input logic [4:0] rd,
                     input logic [31:0] val);
    int   n;
    exp_t e;
    sb.push_back('{pc: pc_m, rd: rd, val: val});
    fetch(code, waits);
    n = 0;
    while (!ret_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk32("retire_latency", 32'(n), 32'd3);
    e = sb.pop_front();
    chk32("retire_pc", rpc_a, e.pc);
    chk1("b_retire", ret_b, 1'b1);
    chk32("b_retire_pc", rpc_b, e.pc);
    dbgAddr = e.rd;
    @(negedge clk);
    chk1("retire_drop", ret_a, 1'b0);
    chk32("retire_pc_hold", rpc_a, e.pc);
    chk32("reg_value", dbg_a, e.val);
    chk32("b_reg_value", dbg_b, e.val);
    pc_m = pc_m + 32'd4;
    chk32("next_fetch_addr", addr_a, pc_m);
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    instrValid = 1'b0;
    instrCode  = 32'h0000_0000;
    dbgAddr    = 5'd1;
    pc_m       = 32'h0000_0000;
    repeat (3) @(negedge clk);
    chk1("rst_req", req_a, 1'b0);
    chk1("rst_retire", ret_a, 1'b0);
    chk1("rst_trap", trap_a, 1'b0);
    chk32("rst_addr", addr_a, 32'h0000_0000);
    chk32("rst_dbg", dbg_a, 32'h0000_0000);
    reset = 1'b0;
    @(negedge clk);
    chk1("req_after_reset", req_a, 1'b1);

    // Arithmetic sequence
    run(32'h0050_0093, 0, 5'd1, 32'h0000_0005);  // addi x1,x0,5
    run(32'hFFD0_0113, 0, 5'd2, 32'hFFFF_FFFD);  // addi x2,x0,-3
    run(32'h0020_81B3, 0, 5'd3, 32'h0000_0002);  // add x3,x1,x2
    run(32'h4020_8233, 0, 5'd4, 32'h0000_0008);  // sub x4,x1,x2
    run(32'h4011_5293, 0, 5'd5, 32'hFFFF_FFFE);  // srai x5,x2,1
    run(32'h0020_B333, 0, 5'd6, 32'h0000_0001);  // sltu x6,x1,x2
    run(32'h1234_53B7, 0, 5'd7, 32'h1234_5000);  // lui x7,0x12345
    run(32'h0070_0013, 3, 5'd0, 32'h0000_0000);  // addi x0,x0,7 with 3 stall cycles
    dbgAddr = 5'd3;
    #1;
    chk32("x3_kept", dbg_a, 32'h0000_0002);

    // Illegal all-zero word traps and freezes the block
    wait_req();
    instrValid = 1'b1;
    instrCode  = 32'h0000_0000;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    @(negedge clk);
    chk1("trap_not_yet", trap_a, 1'b0);
    @(negedge clk);
    chk1("trap_set", trap_a, 1'b1);
    chk1("trap_req_low", req_a, 1'b0);
    chk1("b_trap_set", trap_b, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | ret_a;
    end
    chk1("trap_no_retire", seen, 1'b0);
    chk1("trap_sticky", trap_a, 1'b1);
    chk32("trap_pc_frozen", addr_a, pc_m);

    // Reset clears trap asynchronously
    reset = 1'b1;
    #1;
    chk1("rst_trap_clear", trap_a, 1'b0);
    chk1("rst_req_clear", req_a, 1'b0);
    chk32("rst_pc", addr_a, 32'h0000_0000);
    dbgAddr = 5'd1;
    #1;
    chk32("rst_regs_clear", dbg_a, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    pc_m  = 32'h0000_0000;

    // Reset during EXECUTE of addi x1,x0,9 discards the write
    wait_req();
    instrValid = 1'b1;
    instrCode  = 32'h0090_0093;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      seen = seen | ret_a;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | ret_a;
    end
    chk1("abort_no_retire", seen, 1'b0);
    chk32("abort_x1_zero", dbg_a, 32'h0000_0000);
    chk32("abort_restart_addr", addr_a, 32'h0000_0000);
    chk1("abort_req", req_a, 1'b1);

    // addi x20,x0,1: legal with 32 registers, illegal with 16
    sb.push_back('{pc: pc_m, rd: 5'd20, val: 32'h0000_0001});
    fetch(32'h0010_0A13, 0);
    @(negedge clk);
    chk1("b_trap_not_yet", trap_b, 1'b0);
    @(negedge clk);
    chk1("b_trap_x20", trap_b, 1'b1);
    chk1("b_trap_req_low", req_b, 1'b0);
    @(negedge clk);
    chk1("a_x20_retire", ret_a, 1'b1);
    chk1("b_x20_no_retire", ret_b, 1'b0);
    begin
      exp_t e;
      e = sb.pop_front();
      chk32("a_x20_retire_pc", rpc_a, e.pc);
      dbgAddr = e.rd;
      @(negedge clk);
      chk32("a_x20_value", dbg_a, e.val);
      chk32("b_x20_reads_zero", dbg_b, 32'h0000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
